// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, access owner
// and the memory access size codes.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arbState_e;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } arbOwner_e;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

endpackage

// File: rtl/mem_arb_wait_counter.sv
// Wait-state counter for the memory arbiter: loads the number of extra memory
// cycles when an access is granted and counts down to zero while it runs.
module mem_arb_wait_counter #(
   parameter int CNT_W = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Load,
   input  logic [CNT_W-1:0] LoadValue,
   input  logic             Dec,
   output logic [CNT_W-1:0] Count,
   output logic             Zero
);

   logic [CNT_W-1:0] count_r;

   // Load wins over decrement; the count never wraps below zero
   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_r <= '0;
      end else if (Load) begin
         count_r <= LoadValue;
      end else if (Dec && (count_r != '0)) begin
         count_r <= count_r - CNT_W'(32'd1);
      end else begin
         count_r <= count_r;
      end
   end

   assign Count = count_r;
   assign Zero  = (count_r == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (read
// only) and the data-memory stage (load/store). Data has fixed priority over
// fetch; each access occupies WAIT_STATES+1 memory cycles followed by a
// one-cycle DONE state in which the owner's completion pulse is raised.
// Optional feature macro: FETCH_STARVE_GUARD_EN (bounds consecutive data
// grants while fetch is waiting to MAX_DATA_RUN).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int WAIT_STATES  = 2,
   parameter int CNT_W        = 4,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              FetchReq,
   input  logic [ADDR_W-1:0] FetchAddr,
   input  logic              DataReq,
   input  logic              DataWe,
   input  logic [1:0]        DataSize,
   input  logic [ADDR_W-1:0] DataAddr,
   input  logic [DATA_W-1:0] DataWData,
   output logic [DATA_W-1:0] RData,
   output logic              FetchDone,
   output logic              DataDone,
   output logic              FetchStall,
   output logic              DataStall,
   output logic              MemEn,
   output logic              MemWe,
   output logic [1:0]        MemSize,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic [DATA_W-1:0] MemRData
);

   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
   localparam bit               ZERO_WAIT = (WAIT_STATES == 32'sd0);

   arbState_e         state_r;
   arbOwner_e         owner_r;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wData_r;
   logic [1:0]        size_r;
   logic [DATA_W-1:0] rData_r;
   logic              fetchDone_r;
   logic              dataDone_r;
   logic              memEn_r;
   logic              memWe_r;

   logic [CNT_W-1:0]  count_s;
   logic              zero_s;
   logic              countLoad_s;
   logic              countDec_s;
   logic              grantFetch_s;
   logic              grantData_s;
   logic              grant_s;
   logic              starveForce_s;
   logic              nextWe_s;
   logic              lastNext_s;

   mem_arb_wait_counter #(
      .CNT_W (CNT_W)
   ) uWaitCounter (
      .Clk       (Clk),
      .Reset     (Reset),
      .Load      (countLoad_s),
      .LoadValue (WAIT_LOAD),
      .Dec       (countDec_s),
      .Count     (count_s),
      .Zero      (zero_s)
   );

`ifdef FETCH_STARVE_GUARD_EN
   localparam int RUN_W = $clog2(MAX_DATA_RUN + 32'sd1);

   logic [RUN_W-1:0] runCount_r;

   // Count consecutive data grants made while fetch is waiting; any fetch grant clears it
   always_ff @(posedge Clk) begin
      if (Reset) begin
         runCount_r <= '0;
      end else if (grantFetch_s) begin
         runCount_r <= '0;
      end else if (grantData_s && FetchReq && (runCount_r != RUN_W'(MAX_DATA_RUN))) begin
         runCount_r <= runCount_r + RUN_W'(32'd1);
      end else begin
         runCount_r <= runCount_r;
      end
   end

   assign starveForce_s = FetchReq && (runCount_r == RUN_W'(MAX_DATA_RUN));
`else
   // Pure fixed priority: fetch is never forced ahead of data (a run length is never negative)
   assign starveForce_s = FetchReq && (MAX_DATA_RUN < 32'sd0);
`endif

   // Arbitration: IDLE serves data first; DONE hands the port to the other requester only
   always_comb begin
      grantFetch_s = 1'b0;
      grantData_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (FetchReq && (!DataReq || starveForce_s)) begin
               grantFetch_s = 1'b1;
            end else if (DataReq) begin
               grantData_s = 1'b1;
            end else begin
               grantFetch_s = 1'b0;
               grantData_s  = 1'b0;
            end
         end
         ST_DONE: begin
            if (owner_r == OWN_DATA) begin
               grantFetch_s = FetchReq;
            end else if (owner_r == OWN_FETCH) begin
               grantData_s = DataReq;
            end else begin
               grantFetch_s = 1'b0;
               grantData_s  = 1'b0;
            end
         end
         default: begin
            grantFetch_s = 1'b0;
            grantData_s  = 1'b0;
         end
      endcase
   end

   // Look ahead one cycle so the registered write strobe lands in the final access cycle
   always_comb begin
      grant_s  = grantFetch_s | grantData_s;
      nextWe_s = we_r;
      if (grantData_s) begin
         nextWe_s = DataWe;
      end else if (grantFetch_s) begin
         nextWe_s = 1'b0;
      end else begin
         nextWe_s = we_r;
      end
      if (grant_s) begin
         lastNext_s = ZERO_WAIT;
      end else if ((state_r == ST_ACCESS) && (count_s == CNT_ONE)) begin
         lastNext_s = 1'b1;
      end else begin
         lastNext_s = 1'b0;
      end
      countLoad_s = grant_s;
      countDec_s  = (state_r == ST_ACCESS) && !zero_s;
   end

   // Main FSM: latch the granted request, run the access, pulse the owner's Done
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r     <= ST_IDLE;
         owner_r     <= OWN_NONE;
         we_r        <= 1'b0;
         addr_r      <= '0;
         wData_r     <= '0;
         size_r      <= SIZE_WORD;
         rData_r     <= '0;
         fetchDone_r <= 1'b0;
         dataDone_r  <= 1'b0;
         memEn_r     <= 1'b0;
         memWe_r     <= 1'b0;
      end else begin
         fetchDone_r <= 1'b0;
         dataDone_r  <= 1'b0;
         memWe_r     <= lastNext_s & nextWe_s;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (grantData_s) begin
                  state_r <= ST_ACCESS;
                  owner_r <= OWN_DATA;
                  we_r    <= DataWe;
                  addr_r  <= DataAddr;
                  wData_r <= DataWData;
                  size_r  <= DataSize;
                  memEn_r <= 1'b1;
               end else if (grantFetch_s) begin
                  state_r <= ST_ACCESS;
                  owner_r <= OWN_FETCH;
                  we_r    <= 1'b0;
                  addr_r  <= FetchAddr;
                  size_r  <= SIZE_WORD;
                  memEn_r <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  owner_r <= OWN_NONE;
                  memEn_r <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (zero_s) begin
                  state_r     <= ST_DONE;
                  memEn_r     <= 1'b0;
                  fetchDone_r <= (owner_r == OWN_FETCH);
                  dataDone_r  <= (owner_r == OWN_DATA);
                  if (!we_r) begin
                     rData_r <= MemRData;
                  end else begin
                     rData_r <= rData_r;
                  end
               end else begin
                  memEn_r <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               owner_r <= OWN_NONE;
               memEn_r <= 1'b0;
            end
         endcase
      end
   end

   // Memory strobes are suppressed in the Reset cycle itself so an aborted store never writes
   assign MemEn      = memEn_r & ~Reset;
   assign MemWe      = memWe_r & ~Reset;
   assign MemSize    = size_r;
   assign MemAddr    = addr_r;
   assign MemWData   = wData_r;
   assign RData      = rData_r;
   assign FetchDone  = fetchDone_r;
   assign DataDone   = dataDone_r;
   assign FetchStall = FetchReq & ~fetchDone_r;
   assign DataStall  = DataReq & ~dataDone_r;

endmodule
